// File: rtl/phy_read_capture.sv
// Read-data capture for phy_top: after a programmed latency, pushes rd_len dout words into a
// first-word-fall-through FIFO and opens the DCI read window around the capture burst.
module phy_read_capture #(
  parameter int BUF_DEPTH_LOG2 = 5,
  parameter int LAT_WIDTH      = 6,
  parameter int LEN_WIDTH      = 7,
  parameter int DCI_PRE        = 2,
  parameter int DCI_POST       = 1
) (
  input  logic                      mclk,
  input  logic                      rst_n,
  input  logic                      rd_start,
  input  logic [LAT_WIDTH-1:0]      rd_lat,
  input  logic [LEN_WIDTH-1:0]      rd_len,
  input  logic [63:0]               dout,
  output logic                      busy,
  output logic                      done,
  output logic                      dci_disable_dq,
  output logic [63:0]               rdata,
  output logic                      rvalid,
  input  logic                      rready,
  output logic [BUF_DEPTH_LOG2:0]   level,
  output logic                      overflow
);

  localparam int DEPTH = 1 << BUF_DEPTH_LOG2;
  localparam int PW    = (DCI_POST > 0) ? $clog2(DCI_POST + 1) : 1;

  localparam logic [BUF_DEPTH_LOG2:0] DEPTH_L = (BUF_DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [LAT_WIDTH-1:0]    LAT_ONE = LAT_WIDTH'(1);
  localparam logic [LEN_WIDTH-1:0]    LEN_ONE = LEN_WIDTH'(1);
  localparam logic [PW-1:0]           PST_ONE = PW'(1);
  localparam logic [PW-1:0]           PST_INI = PW'(DCI_POST);

  typedef enum logic [1:0] {IDLE, WAIT_LAT, CAPTURE, POST} state_t;

  state_t                   state;
  logic [LAT_WIDTH-1:0]     lat_cnt;
  logic [LEN_WIDTH-1:0]     len_cnt;
  logic [PW-1:0]            post_cnt;
  logic [LAT_WIDTH-1:0]     eff_lat;

  logic [63:0]              mem [DEPTH];
  logic [BUF_DEPTH_LOG2-1:0] wptr;
  logic [BUF_DEPTH_LOG2-1:0] rptr;
  logic                     cap_vld;
  logic                     fifo_full;
  logic                     push;
  logic                     pop;

  // remaining = cycles until the first capture cycle, seen from the cycle being decided
  function automatic logic dci_open(input logic [LAT_WIDTH-1:0] remaining);
    return int'(remaining) <= DCI_PRE + 1;
  endfunction

  assign eff_lat   = (rd_lat == '0) ? LAT_ONE : rd_lat;
  assign cap_vld   = (state == CAPTURE);
  assign fifo_full = (level == DEPTH_L);
  assign push      = cap_vld && !fifo_full;
  assign rvalid    = (level != '0);
  assign pop       = rvalid && rready;
  assign rdata     = rvalid ? mem[rptr] : '0;

  always_ff @(posedge mclk) begin
    if (!rst_n) begin
      state          <= IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      dci_disable_dq <= 1'b1;
      overflow       <= 1'b0;
      lat_cnt        <= '0;
      len_cnt        <= '0;
      post_cnt       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (rd_start) begin
            overflow <= 1'b0;
            if (rd_len == '0) begin
              done <= 1'b1;
            end else begin
              busy    <= 1'b1;
              len_cnt <= rd_len;
              lat_cnt <= eff_lat - 1'b1;
              if (dci_open(eff_lat)) dci_disable_dq <= 1'b0;
              state   <= (eff_lat == LAT_ONE) ? CAPTURE : WAIT_LAT;
            end
          end
        end
        WAIT_LAT: begin
          if (dci_open(lat_cnt)) dci_disable_dq <= 1'b0;
          if (lat_cnt == LAT_ONE) state <= CAPTURE;
          else                    lat_cnt <= lat_cnt - 1'b1;
        end
        CAPTURE: begin
          if (fifo_full) overflow <= 1'b1;
          len_cnt <= len_cnt - 1'b1;
          if (len_cnt == LEN_ONE) begin
            if (DCI_POST == 0) begin
              state          <= IDLE;
              busy           <= 1'b0;
              done           <= 1'b1;
              dci_disable_dq <= 1'b1;
            end else begin
              state    <= POST;
              post_cnt <= PST_INI;
            end
          end
        end
        POST: begin
          if (post_cnt == PST_ONE) begin
            state          <= IDLE;
            busy           <= 1'b0;
            done           <= 1'b1;
            dci_disable_dq <= 1'b1;
          end else begin
            post_cnt <= post_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // FIFO bookkeeping; full check uses the level at the start of the cycle
  always_ff @(posedge mclk) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      if (push && !pop)      level <= level + 1'b1;
      else if (!push && pop) level <= level - 1'b1;
    end
  end

  always_ff @(posedge mclk) begin
    if (push) mem[wptr] <= dout;
  end

endmodule

// File: tb/tb_phy_read_capture.sv
// Bench for phy_read_capture: schedule/queue reference model checked every cycle plus
// hand-computed expectations for the directed scenarios.
module tb_phy_read_capture;

  localparam int PRE   = 2;
  localparam int POST  = 1;
  localparam int DEPTH = 32;

  logic        mclk = 1'b0;
  logic        rst_n, rd_start, rready;
  logic [5:0]  rd_lat;
  logic [6:0]  rd_len;
  logic [63:0] dout;
  logic        busy, done, dci_disable_dq, rvalid, overflow;
  logic [63:0] rdata;
  logic [5:0]  level;

  phy_read_capture dut (
    .mclk(mclk), .rst_n(rst_n), .rd_start(rd_start), .rd_lat(rd_lat), .rd_len(rd_len),
    .dout(dout), .busy(busy), .done(done), .dci_disable_dq(dci_disable_dq), .rdata(rdata),
    .rvalid(rvalid), .rready(rready), .level(level), .overflow(overflow)
  );

  always #5 mclk = ~mclk;

  longint cyc = 0;
  longint t0  = 0;
  always @(posedge mclk) cyc <= cyc + 1;
  assign dout = 64'(cyc - t0);

  int nchk = 0;
  int nerr = 0;
  bit chk_en = 1'b0;
  logic [63:0] got[$];

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    nchk++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, a, e, cyc - t0);
    end
  endtask

  // Reference model: absolute-cycle window of the current request and a word queue
  bit          act = 1'b0;
  longint      mT = 0, mC = 0, mL = 0, done_at = -1;
  logic [63:0] q[$];
  bit          m_ov = 1'b0;

  function automatic bit in_busy(input longint n);
    return act && n >= mT + 1 && n <= mL + POST;
  endfunction

  function automatic bit dci_low(input longint n);
    longint lo;
    lo = (mC - PRE > mT + 1) ? mC - PRE : mT + 1;
    return act && n >= lo && n <= mL + POST;
  endfunction

  always @(posedge mclk) begin
    longint n, lat;
    int pre;
    bit dopop, dopush;
    n = cyc;
    if (!rst_n) begin
      act = 1'b0; done_at = -1; q.delete(); m_ov = 1'b0;
    end else begin
      pre    = q.size();
      dopop  = pre > 0 && rready;
      dopush = act && n >= mC && n <= mL;
      if (dopush && pre >= DEPTH) m_ov = 1'b1;
      if (dopop) void'(q.pop_front());
      if (dopush && pre < DEPTH) q.push_back(dout);
      if (rd_start && !in_busy(n)) begin
        m_ov = 1'b0;
        if (rd_len == 0) begin
          act = 1'b0;
          done_at = n + 1;
        end else begin
          lat = (rd_lat == 0) ? 1 : longint'(rd_lat);
          act = 1'b1; mT = n; mC = n + lat; mL = mC + rd_len - 1;
          done_at = mL + POST + 1;
        end
      end
    end
  end

  always @(negedge mclk) begin
    if (chk_en) begin
      chk("m_busy", busy, in_busy(cyc));
      chk("m_done", done, cyc == done_at);
      chk("m_dci", dci_disable_dq, !dci_low(cyc));
      chk("m_rvalid", rvalid, q.size() != 0);
      chk("m_rdata", rdata, (q.size() != 0) ? q[0] : 64'h0);
      chk("m_level", level, q.size());
      chk("m_overflow", overflow, m_ov);
      if (rvalid && rready) got.push_back(rdata);
    end
  end

  task automatic step();
    @(posedge mclk);
    #1;
  endtask

  task automatic goto(input int k);
    while (cyc - t0 < k) step();
  endtask

  task automatic begin_req(input int lat, input int len);
    t0 = cyc;
    rd_lat = 6'(lat);
    rd_len = 7'(len);
    rd_start = 1'b1;
    step();
    rd_start = 1'b0;
  endtask

  task automatic wait_done(input int maxc);
    int k;
    k = 0;
    while (!done && k < maxc) begin
      step();
      k++;
    end
    chk("done_seen", done, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; rd_start = 1'b0; rd_lat = '0; rd_len = '0; rready = 1'b0;
    step();
    chk_en = 1'b1;
    step();
    chk("rst_busy", busy, 0);
    chk("rst_dci", dci_disable_dq, 1);
    chk("rst_level", level, 0);
    rst_n = 1'b1;
    step();

    // 1: lat 5, len 4
    rready = 1'b1; got.delete();
    begin_req(5, 4);
    chk("t1_busy_c1", busy, 1);
    goto(2);  chk("t1_dci_c2", dci_disable_dq, 1);
    goto(3);  chk("t1_dci_c3", dci_disable_dq, 0);
    goto(9);  chk("t1_busy_c9", busy, 1); chk("t1_dci_c9", dci_disable_dq, 0);
    goto(10); chk("t1_done_c10", done, 1); chk("t1_busy_c10", busy, 0);
    chk("t1_dci_c10", dci_disable_dq, 1);
    goto(12);
    chk("t1_nwords", got.size(), 4);
    for (int i = 0; i < 4 && i < got.size(); i++) chk("t1_word", got[i], 64'(5 + i));

    // 2: lat 0 treated as 1
    got.delete();
    begin_req(0, 1);
    chk("t2_dci_c1", dci_disable_dq, 0);
    goto(2); chk("t2_dci_c2", dci_disable_dq, 0);
    goto(3); chk("t2_done_c3", done, 1); chk("t2_dci_c3", dci_disable_dq, 1);
    goto(4);
    chk("t2_nwords", got.size(), 1);
    if (got.size() > 0) chk("t2_word", got[0], 64'd1);

    // 3: overflow with no draining, then drain
    rready = 1'b0; got.delete();
    begin_req(1, 40);
    wait_done(60);
    chk("t3_done_cyc", 64'(cyc - t0), 64'd42);
    chk("t3_level_full", level, 32);
    chk("t3_overflow", overflow, 1);
    rready = 1'b1;
    repeat (34) step();
    chk("t3_level_empty", level, 0);
    chk("t3_rvalid", rvalid, 0);
    chk("t3_rdata", rdata, 0);
    chk("t3_nwords", got.size(), 32);
    for (int i = 0; i < 32 && i < got.size(); i++) chk("t3_word", got[i], 64'(i + 1));
    rready = 1'b0;
    begin_req(3, 0);
    chk("t3_ov_clear", overflow, 0);
    chk("t4_len0_done", done, 1);
    chk("t4_len0_busy", busy, 0);
    chk("t4_len0_dci", dci_disable_dq, 1);
    step();

    // 4: rd_start held while busy
    rready = 1'b1; got.delete();
    t0 = cyc; rd_lat = 6'd3; rd_len = 7'd2; rd_start = 1'b1;
    step();
    for (int k = 0; k < 20 && busy; k++) begin
      rd_lat = 6'(k);
      rd_len = 7'(9 + k);
      step();
    end
    rd_start = 1'b0;
    chk("t4_done_cyc", 64'(cyc - t0), 64'd6);
    chk("t4_done", done, 1);
    goto(8);
    chk("t4_nwords", got.size(), 2);
    if (got.size() == 2) begin
      chk("t4_word0", got[0], 64'd3);
      chk("t4_word1", got[1], 64'd4);
    end

    // 5: reset mid-capture
    rready = 1'b0; got.delete();
    begin_req(2, 6);
    goto(4); chk("t5_level_pre", level, 2);
    rst_n = 1'b0;
    step();
    chk("t5_busy", busy, 0); chk("t5_done", done, 0); chk("t5_dci", dci_disable_dq, 1);
    chk("t5_rvalid", rvalid, 0); chk("t5_rdata", rdata, 0); chk("t5_level", level, 0);
    chk("t5_ov", overflow, 0);
    rst_n = 1'b1;
    step();
    rready = 1'b1; got.delete();
    begin_req(1, 2);
    goto(5);
    chk("t5_nwords", got.size(), 2);
    if (got.size() == 2) begin
      chk("t5_word0", got[0], 64'd1);
      chk("t5_word1", got[1], 64'd2);
    end

    // 6a: push and pop at level 1
    rready = 1'b0; got.delete();
    begin_req(1, 3);
    goto(2); chk("t6_level_c2", level, 1);
    rready = 1'b1;
    goto(3); chk("t6_level_c3", level, 1);
    goto(4); chk("t6_level_c4", level, 1);
    goto(5); chk("t6_level_c5", level, 0);
    chk("t6_nwords", got.size(), 3);
    for (int i = 0; i < 3 && i < got.size(); i++) chk("t6_word", got[i], 64'(i + 1));

    // 6b: push and pop while full
    rready = 1'b0; got.delete();
    begin_req(1, 34);
    goto(33); chk("t6b_level_c33", level, 32); chk("t6b_ov_c33", overflow, 0);
    rready = 1'b1;
    step();
    rready = 1'b0;
    chk("t6b_level_c34", level, 31); chk("t6b_ov_c34", overflow, 1);
    goto(36); chk("t6b_done", done, 1); chk("t6b_level_c36", level, 32);
    rready = 1'b1;
    repeat (34) step();
    chk("t6b_nwords", got.size(), 33);
    if (got.size() == 33) begin
      chk("t6b_first", got[0], 64'd1);
      chk("t6b_w32", got[31], 64'd32);
      chk("t6b_last", got[32], 64'd34);
    end
    rready = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
